// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode and funct encodings, ALU control
// codes, the decoded control bundle, the ID/EX pipeline record, and small
// helper functions for instruction decode and immediate extension.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_REGS = 32;

  // Primary opcodes, Instruct[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type function codes, Instruct[5:0]
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_write;
    logic      alu_src;
    logic      reg_dst;
    alu_ctrl_e alu_ctrl;
    logic      branch_eq;
    logic      branch_ne;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    mem_write:  1'b0,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    alu_ctrl:   ALU_AND,
    branch_eq:  1'b0,
    branch_ne:  1'b0
  };

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_dst;
    alu_ctrl_e       alu_ctrl;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '{
    rd1:        '0,
    rd2:        '0,
    imm:        '0,
    rs:         '0,
    rt:         '0,
    rd:         '0,
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    mem_write:  1'b0,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    alu_ctrl:   ALU_AND
  };

  // Unsupported opcodes and unsupported R-type functs both collapse to NOP.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        case (funct)
          FUNCT_ADD: c.alu_ctrl = ALU_ADD;
          FUNCT_SUB: c.alu_ctrl = ALU_SUB;
          FUNCT_AND: c.alu_ctrl = ALU_AND;
          FUNCT_OR:  c.alu_ctrl = ALU_OR;
          FUNCT_SLT: c.alu_ctrl = ALU_SLT;
          default:   c = CTRL_NOP;
        endcase
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        c.alu_ctrl  = ALU_SUB;
        c.branch_eq = 1'b1;
      end
      OP_BNE: begin
        c.alu_ctrl  = ALU_SUB;
        c.branch_ne = 1'b1;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_ctrl  = ALU_ADD;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] v);
    return {{(XLEN-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file with two combinational read ports and one write
// port. Register 0 is hardwired to zero. With BYPASS set, a read of the
// address being written in the same cycle returns the write data.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset (clears all)
//   we_i/waddr_i/wdata_i write port, committed on the rising edge
//   raddr1_i/rdata1_o    read port 1 (combinational)
//   raddr2_i/rdata2_o    read port 2 (combinational)
module reg_file
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [4:0]       raddr1_i,
  output logic [WIDTH-1:0] rdata1_o,
  input  logic [4:0]       raddr2_i,
  output logic [WIDTH-1:0] rdata2_o
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == 5'd0) begin
      rdata1_o = '0;
    end else if (BYPASS && we_i && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == 5'd0) begin
      rdata2_o = '0;
    end else if (BYPASS && we_i && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/decode_unit.sv
// MIPS ID stage: register file read, control decode, branch resolution and
// the ID/EX pipeline register.
// Ports:
//   CLK, RST                  clock, asynchronous active-low reset
//   Instruct, PC_plus4        IF/ID instruction and PC+4
//   CLR_E                     synchronous ID/EX flush (bubble)
//   WB_EN, WB_Addr, WB_Data   writeback port into the register file
//   FwdA_D, FwdB_D, ALUOut_M  branch-compare operand forwarding from MEM
//   PC_Src, PC_branch         branch taken / target (combinational)
//   RD1_E .. ALUCtrl_E        registered ID/EX data and controls
module decode_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          RF_BYPASS = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      Instruct,
  input  logic [WIDTH-1:0] PC_plus4,
  input  logic             CLR_E,
  input  logic             WB_EN,
  input  logic [4:0]       WB_Addr,
  input  logic [WIDTH-1:0] WB_Data,
  input  logic             FwdA_D,
  input  logic             FwdB_D,
  input  logic [WIDTH-1:0] ALUOut_M,
  output logic             PC_Src,
  output logic [WIDTH-1:0] PC_branch,
  output logic [WIDTH-1:0] RD1_E,
  output logic [WIDTH-1:0] RD2_E,
  output logic [WIDTH-1:0] Imm_E,
  output logic [4:0]       Rs_E,
  output logic [4:0]       Rt_E,
  output logic [4:0]       Rd_E,
  output logic             RegWrite_E,
  output logic             MemtoReg_E,
  output logic             MemWrite_E,
  output logic             ALUSrc_E,
  output logic             RegDst_E,
  output logic [2:0]       ALUCtrl_E
);

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [WIDTH-1:0] imm;
  ctrl_t            ctrl;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             operands_eq;
  idex_t            idex_d;
  idex_t            idex_q;

  assign opcode = Instruct[31:26];
  assign rs     = Instruct[25:21];
  assign rt     = Instruct[20:16];
  assign rd     = Instruct[15:11];
  assign funct  = Instruct[5:0];
  assign imm    = sign_ext16(Instruct[15:0]);
  assign ctrl   = decode_ctrl(opcode, funct);

  reg_file #(
    .WIDTH  (WIDTH),
    .BYPASS (RF_BYPASS)
  ) u_reg_file (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .we_i     (WB_EN),
    .waddr_i  (WB_Addr),
    .wdata_i  (WB_Data),
    .raddr1_i (rs),
    .rdata1_o (rs_data),
    .raddr2_i (rt),
    .rdata2_o (rt_data)
  );

  // Branch resolution in ID; forwarded MEM result only when explicitly selected.
  assign cmp_a       = FwdA_D ? ALUOut_M : rs_data;
  assign cmp_b       = FwdB_D ? ALUOut_M : rt_data;
  assign operands_eq = (cmp_a == cmp_b);
  assign PC_Src      = (ctrl.branch_eq && operands_eq) || (ctrl.branch_ne && !operands_eq);
  assign PC_branch   = PC_plus4 + {imm[WIDTH-3:0], 2'b00};

  // ID/EX carries the register-file data, not the forwarded compare operands.
  always_comb begin
    idex_d = IDEX_BUBBLE;
    if (!CLR_E) begin
      idex_d.rd1        = rs_data;
      idex_d.rd2        = rt_data;
      idex_d.imm        = imm;
      idex_d.rs         = rs;
      idex_d.rt         = rt;
      idex_d.rd         = rd;
      idex_d.reg_write  = ctrl.reg_write;
      idex_d.mem_to_reg = ctrl.mem_to_reg;
      idex_d.mem_write  = ctrl.mem_write;
      idex_d.alu_src    = ctrl.alu_src;
      idex_d.reg_dst    = ctrl.reg_dst;
      idex_d.alu_ctrl   = ctrl.alu_ctrl;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idex_q <= IDEX_BUBBLE;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign RD1_E      = idex_q.rd1;
  assign RD2_E      = idex_q.rd2;
  assign Imm_E      = idex_q.imm;
  assign Rs_E       = idex_q.rs;
  assign Rt_E       = idex_q.rt;
  assign Rd_E       = idex_q.rd;
  assign RegWrite_E = idex_q.reg_write;
  assign MemtoReg_E = idex_q.mem_to_reg;
  assign MemWrite_E = idex_q.mem_write;
  assign ALUSrc_E   = idex_q.alu_src;
  assign RegDst_E   = idex_q.reg_dst;
  assign ALUCtrl_E  = idex_q.alu_ctrl;

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the datapath width; only 32 is supported.
REQ-002 SHALL have parameter RF_BYPASS, default 1: 1 returns WB_Data on a same-cycle read of the register being written.
REQ-003 SHALL have port CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port Instruct  in  32  the IF/ID instruction.
REQ-006 SHALL have port PC_plus4  in  32  the IF/ID PC+4.
REQ-007 SHALL have port CLR_E  in  1  synchronous flush of the ID/EX register (bubble insert).
REQ-008 SHALL have ports WB_EN  in  1, WB_Addr  in  5 and WB_Data  in  32, the writeback write port.
REQ-009 SHALL have ports FwdA_D  in  1, FwdB_D  in  1 and ALUOut_M  in  32, branch-compare forwarding.
REQ-010 SHALL have ports PC_Src  out  1 (branch taken) and PC_branch  out  32 (branch target), both combinational.
REQ-011 SHALL have ports RD1_E, RD2_E, Imm_E  out  32 and Rs_E, Rt_E, Rd_E  out  5, all ID/EX data.
REQ-012 SHALL have ports RegWrite_E, MemtoReg_E, MemWrite_E, ALUSrc_E, RegDst_E  out  1 and ALUCtrl_E  out  3, all ID/EX control.

Function
REQ-013 SHALL contain a 32x32 register file; reads combinational, writes at the rising edge when WB_EN=1.
REQ-014 SHALL keep register 0 at zero: writes to it are ignored and reads of it return 0.
REQ-015 SHALL, when RF_BYPASS=1, WB_EN=1 and WB_Addr equal to a nonzero read address, return WB_Data on that read.
REQ-016 SHALL decode the opcode as follows: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 000101 bne, 001000 addi; any other opcode produces all-zero controls (NOP).
REQ-017 SHALL set ALUCtrl from funct for R-type: add 100000->010, sub 100010->110, and 100100->000, or 100101->001, slt 101010->111; any other funct produces all-zero controls.
REQ-018 SHALL use ALUCtrl 010 for lw, sw and addi, and 110 for beq and bne.
REQ-019 SHALL sign-extend Instruct[15:0] to 32 bits to form Imm.
REQ-020 SHALL select branch operands: operand A is ALUOut_M if FwdA_D=1, else rs read data; operand B is ALUOut_M if FwdB_D=1, else rt read data.
REQ-021 SHALL drive PC_Src = (beq AND A==B) OR (bne AND A!=B).
REQ-022 SHALL drive PC_branch = PC_plus4 + (Imm<<2), mod 2^32 (wraps, no overflow flag).
REQ-023 SHALL register RD1/RD2, Imm, Rs=[25:21], Rt=[20:16], Rd=[15:11] and all controls into ID/EX every cycle: latency 1 cycle.
REQ-024 SHALL, when CLR_E=1 at the edge, zero every ID/EX output (bubble).
REQ-025 SHALL forward no branch-compare operands internally unless FwdA_D/FwdB_D are asserted.
REQ-026 SHALL apply writes on WB_EN=1 to the register file regardless of CLR_E.

Reset
REQ-027 SHALL, while RST=0, asynchronously clear all 32 registers and all ID/EX outputs to 0.
REQ-028 SHALL leave PC_Src and PC_branch as pure functions of inputs and register state; after reset, PC_Src=0 for Instruct=0.
REQ-029 SHALL ignore writes while RST=0; the first write after deassertion takes effect at the first rising edge.

Structure
REQ-030 SHALL place opcode, funct and ALUCtrl encodings in the shared package mips_pkg.
REQ-031 SHALL implement the register file as the sub-module reg_file; control decode, branch logic and ID/EX register are inline.

Verification
REQ-032 SHALL verify: write $8=0x0000_0005 via WB, then Instruct add $10,$8,$8 (0x0108_5020) -> next cycle RD1_E=RD2_E=5, ALUCtrl_E=010, RegWrite_E=1, RegDst_E=1.
REQ-033 SHALL verify: WB_EN=1, WB_Addr=9, WB_Data=0xDEAD_BEEF in the same cycle as reading $9 -> RD1_E=0xDEAD_BEEF; WB_Addr=0 -> $0 still reads 0.
REQ-034 SHALL verify: beq $1,$2,-1 with $1=$2=7, PC_plus4=0x0000_0010 -> PC_Src=1, PC_branch=0x0000_000C; the same with bne -> PC_Src=0.
REQ-035 SHALL verify: beq with $1=3, $2=4, FwdB_D=1, ALUOut_M=3 -> PC_Src=1.
REQ-036 SHALL verify: lw decoded with CLR_E=1 at the edge -> all ID/EX outputs 0; RST pulsed low mid-stream -> outputs 0 immediately without a clock, registers read 0.
REQ-037 SHALL verify: opcode 111111 -> all controls 0; PC_plus4=0xFFFF_FFFC, imm=1 -> PC_branch=0x0000_0000.
